registrador_pc: RTL and testbench

Program-counter stage directly downstream of the next-PC select mux (mux_PC4).
- Holds the architectural PC and loads the mux output saida_pc when the datapath advances.
- Produces pc_mais_4 for the upstream branch/jump muxes.
- Runs the instruction-fetch request/acknowledge handshake with instruction memory and latches the fetched word for decode.

---
 rtl/mips_pkg.sv | 15 +
 rtl/registrador_pc_if.sv | 12 +
 rtl/somador_pc4.sv | 9 +
 rtl/registrador_pc.sv | 104 ++++++++++
 tb/tb_registrador_pc.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the PC/fetch datapath: widths, reset address, FSM encoding.
package mips_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [31:0] RESET_ADDR_PADRAO = 32'h0000_0000;
    localparam logic [1:0]  MASCARA_ALINHAMENTO = 2'b00;

    typedef enum logic [1:0] {
        PARTIDA = 2'd0,
        BUSCA   = 2'd1,
        ESPERA  = 2'd2,
        ERRO    = 2'd3
    } estado_t;

endpackage

// File: rtl/registrador_pc_if.sv
// Instruction-fetch request/acknowledge bus between the PC stage and instruction memory.
interface registrador_pc_if #(
    parameter int unsigned WORD_WIDTH = mips_pkg::WORD_WIDTH
);
    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [WORD_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/somador_pc4.sv
// Combinational pc + 4, truncated to the word width; also usable on the branch-target path.
module somador_pc4 #(
    parameter int unsigned WORD_WIDTH = mips_pkg::WORD_WIDTH
) (
    input  logic [WORD_WIDTH-1:0] endereco,
    output logic [WORD_WIDTH-1:0] soma_c
);
    assign soma_c = endereco + WORD_WIDTH'(4);
endmodule

// File: rtl/registrador_pc.sv
// Program-counter register with instruction-fetch handshake and latched instruction word.
module registrador_pc #(
    parameter int unsigned           WORD_WIDTH = mips_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_ADDR = WORD_WIDTH'(mips_pkg::RESET_ADDR_PADRAO)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] saida_pc,
    input  logic                  avanca,
    registrador_pc_if.master      imem,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] pc_mais_4,
    output logic [WORD_WIDTH-1:0] instrucao,
    output logic                  instr_valida,
    output logic                  erro_alinhamento,
    output logic [WORD_WIDTH-1:0] contador_instr
);
    import mips_pkg::*;

    estado_t               estado_q, estado_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic [WORD_WIDTH-1:0] contador_q, contador_d;
    logic                  valida_q, valida_d;
    logic                  req_q, req_d;
    logic                  erro_q, erro_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= PARTIDA;
            pc_q       <= RESET_ADDR;
            instr_q    <= '0;
            contador_q <= '0;
            valida_q   <= 1'b0;
            req_q      <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            contador_q <= contador_d;
            valida_q   <= valida_d;
            req_q      <= req_d;
            erro_q     <= erro_d;
        end
    end

    // imem_req is registered: it is high exactly while the next state is BUSCA
    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        contador_d = contador_q;
        valida_d   = valida_q;
        req_d      = 1'b0;
        erro_d     = erro_q;
        unique case (estado_q)
            PARTIDA: begin
                estado_d = BUSCA;
                req_d    = 1'b1;
            end
            BUSCA: begin
                req_d = 1'b1;
                if (imem.imem_ack) begin
                    instr_d  = imem.imem_rdata;
                    valida_d = 1'b1;
                    req_d    = 1'b0;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (avanca) begin
                    pc_d       = saida_pc;
                    valida_d   = 1'b0;
                    contador_d = contador_q + WORD_WIDTH'(1);
                    if (saida_pc[1:0] == MASCARA_ALINHAMENTO) begin
                        req_d    = 1'b1;
                        estado_d = BUSCA;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = ERRO;
                    end
                end
            end
            ERRO: begin
                valida_d = 1'b0;
            end
            default: estado_d = PARTIDA;
        endcase
    end

    somador_pc4 #(.WORD_WIDTH(WORD_WIDTH)) u_somador (
        .endereco (pc_q),
        .soma_c   (pc_mais_4)
    );

    assign imem.imem_req    = req_q;
    assign imem.imem_addr   = pc_q;
    assign pc               = pc_q;
    assign instrucao        = instr_q;
    assign instr_valida     = valida_q;
    assign erro_alinhamento = erro_q;
    assign contador_instr   = contador_q;
endmodule

// File: tb/tb_registrador_pc.sv
// Self-checking bench for registrador_pc: directed vector table, corner sequences, random vs. reference model.
module tb_registrador_pc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] saida_pc;
    logic        avanca;
    logic [31:0] pc, pc_mais_4, instrucao, contador_instr;
    logic        instr_valida, erro_alinhamento;

    registrador_pc_if #(.WORD_WIDTH(32)) bus ();

    registrador_pc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .saida_pc         (saida_pc),
        .avanca           (avanca),
        .imem             (bus),
        .pc               (pc),
        .pc_mais_4        (pc_mais_4),
        .instrucao        (instrucao),
        .instr_valida     (instr_valida),
        .erro_alinhamento (erro_alinhamento),
        .contador_instr   (contador_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction lifecycle as booleans (booting, fetch pending, word held, dead)
    bit          m_boot, m_fetching, m_holding, m_dead, m_err;
    logic [31:0] m_pc, m_instr, m_cnt;

    typedef struct {
        logic        av;
        logic [31:0] saida;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_err;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tab[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_fetching = 0; m_holding = 0; m_dead = 0; m_err = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic model_edge();
        if (m_dead) begin
        end else if (m_holding) begin
            if (avanca) begin
                m_pc      = saida_pc;
                m_cnt     = m_cnt + 32'd1;
                m_holding = 0;
                if (saida_pc % 4 != 0) begin
                    m_dead = 1;
                    m_err  = 1;
                end else begin
                    m_fetching = 1;
                end
            end
        end else if (m_fetching) begin
            if (bus.imem_ack) begin
                m_instr    = bus.imem_rdata;
                m_fetching = 0;
                m_holding  = 1;
            end
        end else if (m_boot) begin
            m_boot     = 0;
            m_fetching = 1;
        end
    endtask

    task automatic check_model();
        chk("imem_req",         32'(bus.imem_req),         32'(m_fetching));
        chk("imem_addr",        bus.imem_addr,             m_pc);
        chk("pc",               pc,                        m_pc);
        chk("pc_mais_4",        pc_mais_4,                 m_pc + 32'd4);
        chk("instrucao",        instrucao,                 m_instr);
        chk("instr_valida",     32'(instr_valida),         32'(m_holding));
        chk("erro_alinhamento", 32'(erro_alinhamento),     32'(m_err));
        chk("contador_instr",   contador_instr,            m_cnt);
    endtask

    // One clock: model follows the inputs present at the edge, outputs checked 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic av, input logic [31:0] s, input logic ack, input logic [31:0] rd);
        avanca = av; saida_pc = s; bus.imem_ack = ack; bus.imem_rdata = rd;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released after it
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_model();
        @(posedge clk);
        #1 check_model();
        rst_n = 1'b1;
    endtask

    logic [31:0] s_rand, pc_hold, instr_hold, cnt_hold;
    int          dead_cycles;

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 check_model();
        chk("reset_pc", pc, 32'h0);
        chk("reset_req", 32'(bus.imem_req), 32'h0);
        rst_n = 1'b1;

        tab[0]  = '{0, 32'd0,    1, 32'h2008_0005, 1, 0, 32'd0,    32'd0, 0, 32'h0};
        tab[1]  = '{0, 32'd0,    1, 32'h2008_0005, 0, 1, 32'd0,    32'd0, 0, 32'h2008_0005};
        tab[2]  = '{1, 32'd44,   0, 32'h0,         1, 0, 32'd44,   32'd1, 0, 32'h2008_0005};
        tab[3]  = '{0, 32'd0,    1, 32'h8C09_0000, 0, 1, 32'd44,   32'd1, 0, 32'h8C09_0000};
        tab[4]  = '{1, 32'd1012, 1, 32'hDEAD_BEEF, 1, 0, 32'd1012, 32'd2, 0, 32'h8C09_0000};
        tab[5]  = '{1, 32'd2000, 0, 32'h0,         1, 0, 32'd1012, 32'd2, 0, 32'h8C09_0000};
        tab[6]  = '{0, 32'd0,    0, 32'h0,         1, 0, 32'd1012, 32'd2, 0, 32'h8C09_0000};
        tab[7]  = '{0, 32'd0,    0, 32'h0,         1, 0, 32'd1012, 32'd2, 0, 32'h8C09_0000};
        tab[8]  = '{0, 32'd0,    1, 32'h0800_00FF, 0, 1, 32'd1012, 32'd2, 0, 32'h0800_00FF};
        tab[9]  = '{1, 32'd46,   0, 32'h0,         0, 0, 32'd46,   32'd3, 1, 32'h0800_00FF};
        tab[10] = '{1, 32'd100,  1, 32'h1234_5678, 0, 0, 32'd46,   32'd3, 1, 32'h0800_00FF};
        tab[11] = '{1, 32'd0,    1, 32'h1234_5678, 0, 0, 32'd46,   32'd3, 1, 32'h0800_00FF};

        for (int i = 0; i < 12; i++) begin
            drive(tab[i].av, tab[i].saida, tab[i].ack, tab[i].rdata);
            tick();
            chk($sformatf("vec%0d_req", i),   32'(bus.imem_req),     32'(tab[i].e_req));
            chk($sformatf("vec%0d_valid", i), 32'(instr_valida),     32'(tab[i].e_valid));
            chk($sformatf("vec%0d_pc", i),    pc,                    tab[i].e_pc);
            chk($sformatf("vec%0d_addr", i),  bus.imem_addr,         tab[i].e_pc);
            chk($sformatf("vec%0d_pc4", i),   pc_mais_4,             tab[i].e_pc + 32'd4);
            chk($sformatf("vec%0d_cnt", i),   contador_instr,        tab[i].e_cnt);
            chk($sformatf("vec%0d_err", i),   32'(erro_alinhamento), 32'(tab[i].e_err));
            chk($sformatf("vec%0d_instr", i), instrucao,             tab[i].e_instr);
        end

        // Reset while a fetch of 1012 is outstanding
        pulse_reset();
        drive(0, 32'h0, 1, 32'h0000_0001); tick();
        tick();
        drive(1, 32'd1012, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 32'h0); tick();
        chk("busca_req_1012", 32'(bus.imem_req), 32'h1);
        chk("busca_addr_1012", bus.imem_addr, 32'd1012);
        pulse_reset();
        chk("rst_mid_pc", pc, 32'h0);
        chk("rst_mid_req", 32'(bus.imem_req), 32'h0);
        chk("rst_mid_valid", 32'(instr_valida), 32'h0);
        chk("rst_mid_cnt", contador_instr, 32'h0);
        drive(0, 32'h0, 1, 32'hAAAA_0000); tick();
        chk("resume_req", 32'(bus.imem_req), 32'h1);
        chk("resume_addr", bus.imem_addr, 32'h0);
        tick();
        chk("resume_instr", instrucao, 32'hAAAA_0000);

        // Top-of-address-space PC, long stall, then self-loop refetch
        drive(1, 32'hFFFF_FFFC, 0, 32'h0); tick();
        chk("wrap_pc4", pc_mais_4, 32'h0);
        drive(0, 32'h0, 1, 32'h5555_AAAA); tick();
        pc_hold = pc; instr_hold = instrucao; cnt_hold = contador_instr;
        for (int i = 0; i < 10; i++) begin
            drive(0, $urandom(), 1'($urandom_range(0, 1)), $urandom());
            tick();
            chk("stall_pc", pc, 32'hFFFF_FFFC);
            chk("stall_instr", instrucao, 32'h5555_AAAA);
        end
        drive(1, 32'hFFFF_FFFC, 0, 32'h0); tick();
        chk("selfloop_req", 32'(bus.imem_req), 32'h1);
        chk("selfloop_addr", bus.imem_addr, pc_hold);
        chk("selfloop_cnt", contador_instr, cnt_hold + 32'd1);
        drive(0, 32'h0, 1, 32'h0BAD_F00D); tick();
        chk("selfloop_instr_new", 32'(instrucao != instr_hold), 32'h1);

        // Randomized traffic against the model
        dead_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            s_rand = $urandom();
            if ($urandom_range(0, 15) != 0) s_rand[1:0] = 2'b00;
            drive(1'($urandom_range(0, 9) < 4), s_rand, 1'($urandom_range(0, 1)), $urandom());
            tick();
            dead_cycles = m_dead ? dead_cycles + 1 : 0;
            if (dead_cycles > 4 || $urandom_range(0, 99) == 0) begin
                pulse_reset();
                dead_cycles = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
